// File: rtl/main.sv
// rtl/main.sv - triangle-ramped PWM H-bridge driver with button-toggled direction
// Optional dead time on direction change: define MAIN_DEADTIME_EN.
module main #(
  parameter int N = 4,
  parameter int M = 11
) (
  input  logic       clk,
  input  logic [1:0] buttons,
  input  logic       ena,
  output logic       pwm_out_A,
  output logic       pwm_out_B,
  output logic [1:0] leds
);

  logic [M-1:0] r_presc;
  logic [N-1:0] r_cnt;
  logic [N-1:0] r_duty;
  logic [N-1:0] r_duty_act;
  logic         r_up;
  logic         r_dir;
  logic         r_sync1;
  logic         r_sync2;
  logic         r_hist;
  logic         r_pwm_a;
  logic         r_pwm_b;

  logic w_rst;
  logic w_step;
  logic w_cnt_last;
  logic w_toggle;
  logic w_raw;
  logic w_block;

  assign w_rst      = buttons[0];
  assign w_step     = ena && (r_presc == {M{1'b1}});
  assign w_cnt_last = (r_cnt == {N{1'b1}});
  assign w_toggle   = r_sync2 & ~r_hist;
  assign w_raw      = (r_cnt < r_duty_act);

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_presc    <= '0;
      r_cnt      <= '0;
      r_duty_act <= '0;
    end else if (ena) begin
      r_presc <= r_presc + 1'b1;
      r_cnt   <= r_cnt + 1'b1;
      // Shadow load on the last count so every period starts with one duty value
      if (w_cnt_last) r_duty_act <= r_duty;
    end
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_duty <= '0;
      r_up   <= 1'b1;
    end else if (w_step) begin
      if (r_up) begin
        if (r_duty == {N{1'b1}}) begin
          r_up   <= 1'b0;
          r_duty <= r_duty - 1'b1;
        end else begin
          r_duty <= r_duty + 1'b1;
        end
      end else begin
        if (r_duty == '0) begin
          r_up   <= 1'b1;
          r_duty <= {{(N-1){1'b0}}, 1'b1};
        end else begin
          r_duty <= r_duty - 1'b1;
        end
      end
    end
  end

  // Button synchronizer and rising-edge detector; runs regardless of ena
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
      r_dir   <= 1'b0;
    end else begin
      r_sync1 <= buttons[1];
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
      if (w_toggle) r_dir <= ~r_dir;
    end
  end

`ifdef MAIN_DEADTIME_EN
  logic [N:0] r_dead;

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_dead <= '0;
    end else if (w_toggle) begin
      r_dead <= {1'b1, {N{1'b0}}};
    end else if (ena && (r_dead != '0)) begin
      r_dead <= r_dead - 1'b1;
    end
  end

  assign w_block = (r_dead != '0);
`else
  assign w_block = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_rst || !ena) begin
      r_pwm_a <= 1'b0;
      r_pwm_b <= 1'b0;
    end else begin
      r_pwm_a <= w_raw & ~r_dir & ~w_block;
      r_pwm_b <= w_raw &  r_dir & ~w_block;
    end
  end

  assign pwm_out_A = r_pwm_a;
  assign pwm_out_B = r_pwm_b;
  assign leds      = {r_up, r_dir};

endmodule

// File: tb/tb_main.sv
// tb/tb_main.sv - randomized scoreboard bench for main (N=4, M=11)
module tb_main;

  localparam int N = 4;
  localparam int M = 11;
  localparam int PER = 1 << N;
  localparam int STEP = 1 << M;
  localparam int TOP = PER - 1;

  logic       clk = 1'b0;
  logic [1:0] buttons = 2'b01;
  logic       ena = 1'b1;
  logic       pwm_out_A;
  logic       pwm_out_B;
  logic [1:0] leds;

  main #(.N(N), .M(M)) dut (
    .clk(clk),
    .buttons(buttons),
    .ena(ena),
    .pwm_out_A(pwm_out_A),
    .pwm_out_B(pwm_out_B),
    .leds(leds)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       a;
    logic       b;
    logic [1:0] l;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  bit   stim_done = 0;

  // Reference model: everything follows from the count of enabled cycles since reset
  int e = 0;
  bit dir_m = 0;

  function automatic int tri_duty(int k);
    int r;
    r = k % (2 * TOP);
    return (r <= TOP) ? r : (2 * TOP - r);
  endfunction

  function automatic bit up_of(int k);
    int r;
    r = k % (2 * TOP);
    return (k == 0) || (r >= 1 && r <= TOP);
  endfunction

  function automatic int dact(int ev);
    int last_load;
    if (ev < PER) return 0;
    last_load = (ev / PER) * PER - 1;
    return tri_duty(last_load / STEP);
  endfunction

  task automatic tick(input bit en, input bit rst, input bit btn, input bit tog);
    exp_t x;
    bit raw;
    @(negedge clk);
    ena = en;
    buttons = {btn, rst};
    if (rst) begin
      e = 0;
      dir_m = 0;
      x.a = 1'b0;
      x.b = 1'b0;
      x.l = 2'b10;
    end else begin
      if (en) begin
        raw = (e % PER) < dact(e);
        x.a = raw & ~dir_m;
        x.b = raw & dir_m;
        e++;
      end else begin
        x.a = 1'b0;
        x.b = 1'b0;
      end
      if (tog) dir_m = ~dir_m;
      x.l = {up_of(e / STEP), dir_m};
    end
    q.push_back(x);
  endtask

  task automatic press();
    tick(0, 0, 1, 0);
    tick(0, 0, 1, 0);
    tick(0, 0, 1, 1);
    tick(0, 0, 1, 0);
    repeat (4) tick(0, 0, 0, 0);
  endtask

  always begin
    exp_t x;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      total++;
      if (pwm_out_A !== x.a) begin
        bad++;
        $display("FAIL pwm_out_A t=%0t got=%b want=%b", $time, pwm_out_A, x.a);
      end
      total++;
      if (pwm_out_B !== x.b) begin
        bad++;
        $display("FAIL pwm_out_B t=%0t got=%b want=%b", $time, pwm_out_B, x.b);
      end
      total++;
      if (leds !== x.l) begin
        bad++;
        $display("FAIL leds t=%0t got=%b want=%b", $time, leds, x.l);
      end
    end
  end

  initial begin
    int guard;
    int op;
    int len;
    // Reset with the direction button held, released together with reset
    tick(1, 1, 1, 0);
    tick(1, 1, 1, 0);
    // Full triangle and back up to duty 2
    repeat (32 * STEP) tick(1, 0, 0, 0);
    // Direction change, then run to duty 7 and reset mid-run
    press();
    guard = 0;
    while (tri_duty(e / STEP) != 7 && guard < 20000) begin
      tick(1, 0, 0, 0);
      guard++;
    end
    total++;
    if (guard >= 20000) begin
      bad++;
      $display("FAIL reach_duty7 got=%0d want=7", tri_duty(e / STEP));
    end
    repeat (37) tick(1, 0, 0, 0);
    tick(1, 1, 0, 0);
    repeat (40) tick(1, 0, 0, 0);
    // Randomized mix of run, disable, press and reset
    for (int i = 0; i < 30; i++) begin
      op = $urandom_range(0, 9);
      if (op <= 5) begin
        len = $urandom_range(1, 300);
        repeat (len) tick(1, 0, 0, 0);
      end else if (op <= 7) begin
        len = $urandom_range(1, 100);
        repeat (len) tick(0, 0, 0, 0);
      end else if (op == 8) begin
        press();
      end else begin
        tick($urandom_range(0, 1), 1, 0, 0);
      end
    end
    repeat (4) @(negedge clk);
    stim_done = 1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
